// File: rtl/axis_adapter_cobs_decoder.sv
// COBS byte-stream decoder: splits the input on 0x00 delimiters and emits the
// decoded payload as AXI-Stream with tlast at frame end and tuser on bad frames.
module axis_adapter_cobs_decoder #(
  parameter int MAX_FRAME_LEN = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       frame_good,
  output logic       frame_error
);
  localparam int CW = $clog2(MAX_FRAME_LEN + 2);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_FRAME_LEN);

  typedef enum logic [1:0] {DROP, CODE, DATA} state_t;

  state_t        state, state_n;
  logic [7:0]    rem, rem_n;
  logic          ff, ff_n;
  logic          zero_pending, zero_pending_n;
  logic [7:0]    hold_data, hold_data_n;
  logic          hold_valid, hold_valid_n;
  logic [CW-1:0] byte_count, byte_count_n;
  logic          drop_err, drop_err_n;

  logic          accept, do_push;
  logic [7:0]    push_byte;
  logic          emit, emit_last, emit_user;
  logic          good_n, err_n;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_n        = state;
    rem_n          = rem;
    ff_n           = ff;
    zero_pending_n = zero_pending;
    hold_data_n    = hold_data;
    hold_valid_n   = hold_valid;
    byte_count_n   = byte_count;
    drop_err_n     = drop_err;
    do_push        = 1'b0;
    push_byte      = 8'h00;
    emit           = 1'b0;
    emit_last      = 1'b0;
    emit_user      = 1'b0;
    good_n         = 1'b0;
    err_n          = 1'b0;

    if (accept && s_axis_tdata == 8'h00) begin
      unique case (state)
        DROP: err_n = drop_err;
        CODE: if (hold_valid) begin
          emit      = 1'b1;
          emit_last = 1'b1;
          good_n    = 1'b1;
        end
        default: begin
          emit      = hold_valid;
          emit_last = 1'b1;
          emit_user = 1'b1;
          err_n     = 1'b1;
        end
      endcase
      state_n        = CODE;
      rem_n          = 8'h00;
      zero_pending_n = 1'b0;
      hold_valid_n   = 1'b0;
      byte_count_n   = '0;
      drop_err_n     = 1'b0;
    end else if (accept) begin
      unique case (state)
        DROP: ;
        CODE: begin
          do_push        = zero_pending;
          zero_pending_n = 1'b0;
          rem_n          = s_axis_tdata - 8'd1;
          ff_n           = (s_axis_tdata == 8'hFF);
          if (s_axis_tdata == 8'd1) zero_pending_n = 1'b1;
          else                      state_n        = DATA;
        end
        default: begin
          do_push   = 1'b1;
          push_byte = s_axis_tdata;
          rem_n     = rem - 8'd1;
          if (rem == 8'd1) begin
            state_n        = CODE;
            zero_pending_n = !ff;
          end
        end
      endcase

      // A push past the frame limit closes the frame as bad and discards the new byte.
      if (do_push) begin
        if (byte_count == MAX_C) begin
          emit           = hold_valid;
          emit_last      = 1'b1;
          emit_user      = 1'b1;
          hold_valid_n   = 1'b0;
          zero_pending_n = 1'b0;
          state_n        = DROP;
          drop_err_n     = 1'b1;
        end else begin
          emit         = hold_valid;
          hold_data_n  = push_byte;
          hold_valid_n = 1'b1;
          if (byte_count != '1) byte_count_n = byte_count + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= DROP;
      rem           <= 8'h00;
      ff            <= 1'b0;
      zero_pending  <= 1'b0;
      hold_data     <= 8'h00;
      hold_valid    <= 1'b0;
      byte_count    <= '0;
      drop_err      <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_good    <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state        <= state_n;
      rem          <= rem_n;
      ff           <= ff_n;
      zero_pending <= zero_pending_n;
      hold_data    <= hold_data_n;
      hold_valid   <= hold_valid_n;
      byte_count   <= byte_count_n;
      drop_err     <= drop_err_n;
      frame_good   <= good_n;
      frame_error  <= err_n;
      if (emit) begin
        m_axis_tdata  <= hold_data;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= emit_last;
        m_axis_tuser  <= emit_user;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/axis_adapter_cobs_decoder.md
# axis_adapter_cobs_decoder

Byte-stream COBS decoder: the receive-side counterpart of the accelerometer COBS encoder. It takes the raw 8-bit byte stream from the UART receiver, splits it into frames on 0x00 delimiters, and strips the COBS framing. It emits the decoded payload as an 8-bit AXI-Stream, with `tlast` marking the end of each frame and `tuser` flagging bad frames. It sits between the UART `rx_stream` and any downstream command or packet consumer in the `clk` domain.

## Interface
- `MAX_FRAME_LEN`, default 256: maximum decoded payload bytes per frame; a longer frame is an error.
- `clk  input  1`: system clock; all logic is on its rising edge.
- `reset  input  1`: synchronous, active-high reset.
- `s_axis_tdata  input  8`: COBS-encoded byte; 0x00 is the frame delimiter.
- `s_axis_tvalid  input  1`: input byte valid.
- `s_axis_tready  output  1`: decoder accepts a byte this cycle.
- `m_axis_tdata  output  8`: decoded payload byte.
- `m_axis_tvalid  output  1`: output beat valid.
- `m_axis_tready  input  1`: downstream accepts the beat.
- `m_axis_tlast  output  1`: last byte of the frame.
- `m_axis_tuser  output  1`: valid with `tlast`; 1 means the frame is bad (truncated or overflowed).
- `frame_good  output  1`: one-cycle pulse when a frame ends without error and has at least 1 byte.
- `frame_error  output  1`: one-cycle pulse when an erroneous frame's delimiter is consumed.

## Operation
- Reset value of every output is 0, except `s_axis_tready`.
- Input ready: `s_axis_tready = !m_axis_tvalid || m_axis_tready`.
- Each accepted input byte produces at most one output beat.
- Output is a single register stage. `m_axis_*` holds stable while `tvalid && !tready`.
- Hold register (`hold_data`, `hold_valid`):
  - Each decoded byte is pushed into the hold register.
  - If the hold register is already occupied, its old content moves to the output with `tlast=0`.
  - This one-byte delay lets `tlast` be attached to the correct byte when the delimiter arrives.
- State `DROP`:
  - This is the reset state. The decoder discards all non-zero bytes.
  - On 0x00, go to `CODE`.
  - If `DROP` was entered by overflow, that delimiter pulses `frame_error`.
- State `CODE` (expecting a code byte `c`, non-zero):
  - If `zero_pending` is set, push 0x00 into the hold register and clear `zero_pending`.
  - Set `rem = c-1` and `ff = (c==0xFF)`.
  - If `rem==0`, stay in `CODE` and set `zero_pending = !ff`. Otherwise go to `DATA`.
- State `DATA` (non-zero byte):
  - Push the byte into the hold register and decrement `rem`.
  - When `rem` reaches 0, go to `CODE` and set `zero_pending = !ff`.
- Delimiter 0x00 in `CODE` (normal end of frame):
  - Discard `zero_pending`.
  - If `hold_valid`, emit the held byte with `tlast=1`, `tuser=0`, and pulse `frame_good`.
  - If the frame is empty, produce no beat and no pulse.
- Delimiter 0x00 in `DATA` (truncated block):
  - If `hold_valid`, emit the held byte with `tlast=1`, `tuser=1`.
  - Pulse `frame_error` in either case.
- On any delimiter: clear the hold register, `zero_pending`, `rem` and `byte_count`, then enter `CODE`.
- Overflow:
  - `byte_count` counts pushes into the hold register, including implied zeros. Width is `$clog2(MAX_FRAME_LEN+2)`; it saturates and never wraps.
  - A push that would make `byte_count` equal `MAX_FRAME_LEN+1` is an overflow.
  - On overflow, the held byte is emitted with `tlast=1`, `tuser=1`, the new byte is dropped, and the decoder enters `DROP`.
- Implied zeros are never emitted at the end of a frame, so trailing zero ambiguity cannot occur.
- Reset mid-frame:
  - Any in-flight output beat is lost, with no `tlast`.
  - The decoder resynchronises by starting in `DROP`; the first complete frame is the one after the next 0x00.

## Timing
- Input accept: byte is accepted when `s_axis_tvalid && s_axis_tready` at the rising edge.
- Decoded byte N appears on `m_axis` the cycle after the input byte that produces byte N+1, or the terminating delimiter, is accepted.
- Throughput: 1 byte/cycle with `m_axis_tready=1`. Code bytes and empty frames produce bubbles.
- `frame_good` / `frame_error` assert in the cycle after the delimiter is accepted, coincident with the `tlast` beat becoming valid.
- Reset is sampled at the clock edge and dominates any simultaneous input handshake.

## Test plan
- Normal frame:
  - Stimulus: after reset send 00, 03 11 22 02 33 00.
  - Required: beats 11, 22, 00, 33; `tlast` only on 33; `tuser=0`; one `frame_good` pulse.
- Maximum block:
  - Stimulus: 00, FF 01..FE 00.
  - Required: exactly 254 bytes 01..FE; `tlast` on FE; no implied 0x00 appended.
- Truncated frame:
  - Stimulus: 00, 05 AA BB 00.
  - Required: AA, then BB with `tlast=1`, `tuser=1`; `frame_error` pulse; `frame_good` stays 0.
- Overflow:
  - Stimulus: `MAX_FRAME_LEN=4`; send 00, 06 01 02 03 04 05 00 02 AA 00.
  - Required: 01 02 03, then 04 with `tlast=1`, `tuser=1`; byte 05 is dropped; `frame_error` pulses at the following 00.
  - Then AA with `tlast=1`, `tuser=0`, and a `frame_good` pulse.
- Backpressure:
  - Stimulus: repeat the normal-frame scenario with `m_axis_tready` randomised at 50%.
  - Required: identical output sequence; `m_axis_*` stable while stalled; no byte lost or duplicated.
- Empty frames and mid-frame reset:
  - Stimulus: 00 00 01 00.
  - Required: no beats, no pulses.
  - Stimulus: assert `reset` in the middle of 03 11 22, then send 33 00 02 44 00.
  - Required: only 44 is emitted, with `tlast=1`.
